// File: rtl/demux_registrado.sv
// -----------------------------------------------------------------------------
// demux_registrado
//   Registered 1:4 demultiplexer. One LARGURA-bit word from a single producer
//   is steered into one of four one-entry holding registers (S0..S3). Every
//   channel has its own valid/ready handshake, so consumers stall
//   independently of one another. A channel that is drained and refilled on
//   the same edge keeps valida set, which sustains one word per cycle.
//
// Optional feature (macro DEMUX_ROUND_ROBIN_EN):
//   When defined, chave is ignored. An internal 2-bit pointer picks the
//   destination channel and advances only when a word is accepted, so words
//   land strictly in the order S0,S1,S2,S3,S0,...
//   When undefined (default), the destination is chave.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active-high
//   entrada         in   LARGURA  input data word
//   chave           in   2        destination select (00->S0 .. 11->S3)
//   entrada_valida  in   1        producer presents a word
//   entrada_pronta  out  1        block can accept a word this cycle
//   S0..S3          out  LARGURA  channel data registers
//   valida          out  4        valida[i]: S<i> holds an unconsumed word
//   pronta          in   4        pronta[i]: consumer i takes S<i> this cycle
//   contador        out  8        accepted-word count, wraps modulo 256
// -----------------------------------------------------------------------------
module demux_registrado #(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA-1:0] entrada,
    input  logic [1:0]         chave,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    output logic [LARGURA-1:0] S0,
    output logic [LARGURA-1:0] S1,
    output logic [LARGURA-1:0] S2,
    output logic [LARGURA-1:0] S3,
    output logic [3:0]         valida,
    input  logic [3:0]         pronta,
    output logic [7:0]         contador
);

    logic [LARGURA-1:0] r_dados [4];
    logic [3:0]         r_valida;
    logic [7:0]         r_contador;
    logic [1:0]         w_sel;
    logic               w_pronta;
    logic               w_aceita;
    logic [3:0]         w_carrega;

`ifdef DEMUX_ROUND_ROBIN_EN
    logic [1:0]         r_rr;

    // Destination channel comes from the round-robin pointer
    always_comb begin
        w_sel = r_rr;
    end

    // Round-robin pointer: advances 3->0 only on an accepted word, so an
    // unaccepted word keeps the producer waiting on the same channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 2'd0;
        end else if (w_aceita) begin
            r_rr <= r_rr + 2'd1;
        end else begin
            r_rr <= r_rr;
        end
    end
`else
    // Destination channel comes straight from chave
    always_comb begin
        w_sel = chave;
    end
`endif

    // Ready toward the producer: the chosen slot is empty or is being drained
    // this same edge; forced low while reset is held
    always_comb begin
        w_pronta = 1'b0;
        if (rst) begin
            w_pronta = 1'b0;
        end else begin
            w_pronta = ~r_valida[w_sel] | pronta[w_sel];
        end
        w_aceita = entrada_valida & w_pronta;
    end

    // One-hot load enable for the channel receiving the accepted word
    always_comb begin
        w_carrega = 4'b0000;
        if (w_aceita) begin
            case (w_sel)
                2'd0:    w_carrega = 4'b0001;
                2'd1:    w_carrega = 4'b0010;
                2'd2:    w_carrega = 4'b0100;
                2'd3:    w_carrega = 4'b1000;
                default: w_carrega = 4'b0000;
            endcase
        end else begin
            w_carrega = 4'b0000;
        end
    end

    // Channel data registers: load on accept, otherwise hold (a drained
    // channel keeps its last word visible)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_dados[i] <= {LARGURA{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_carrega[i]) begin
                    r_dados[i] <= entrada;
                end else begin
                    r_dados[i] <= r_dados[i];
                end
            end
        end
    end

    // Channel valid flags: a load wins over a same-edge drain so a channel can
    // be emptied and refilled in one cycle; pronta on an empty slot is inert
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valida <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_carrega[i]) begin
                    r_valida[i] <= 1'b1;
                end else begin
                    r_valida[i] <= r_valida[i] & ~pronta[i];
                end
            end
        end
    end

    // Accepted-word counter, wraps silently from 255 to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_contador <= 8'd0;
        end else if (w_aceita) begin
            r_contador <= r_contador + 8'd1;
        end else begin
            r_contador <= r_contador;
        end
    end

    assign entrada_pronta = w_pronta;
    assign S0             = r_dados[0];
    assign S1             = r_dados[1];
    assign S2             = r_dados[2];
    assign S3             = r_dados[3];
    assign valida         = r_valida;
    assign contador       = r_contador;

endmodule
